// File: rtl/line_clear_engine_if.sv
// Handshake and board transfer bundle between the landing logic, the line clear engine and the renderer.
interface line_clear_engine_if #(
    parameter int BW = 145
);
    logic          start;
    logic [BW-1:0] board_in;
    logic          busy;
    logic          done;
    logic [BW-1:0] board_out;
    logic [3:0]    rows_cleared;
    logic [9:0]    score_add;

    modport master (
        output start, board_in,
        input  busy, done, board_out, rows_cleared, score_add
    );

    modport slave (
        input  start, board_in,
        output busy, done, board_out, rows_cleared, score_add
    );
endinterface

// File: rtl/line_clear_engine.sv
// Removes completed rows from the merged 12x12 background and collapses the rows above downward.
//
// state | meaning
// IDLE  | waiting for start, captures board_in
// SCAN  | test row r for full, one row per cycle from bottom to top
// SHIFT | drop rows r-1..0 by one, inject an empty top row
// DONE  | results valid, done pulse
module line_clear_engine #(
    parameter int COLS           = 12,
    parameter int ROWS           = 12,
    parameter int POINTS_PER_ROW = 10
) (
    input  logic           clk,
    input  logic           resetn,
    line_clear_engine_if.slave bus
);
    localparam int BW = COLS*ROWS + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] work;
    logic [BW-1:0] shifted;
    logic [3:0]    r;
    logic [3:0]    cnt;
    logic [BW-1:0] board_out_q;
    logic [3:0]    rows_cleared_q;
    logic [9:0]    score_add_q;
    logic          row_full;

    assign row_full = &work[r*COLS +: COLS];

    // Rows below r and the unused top bit are carried over untouched.
    always_comb begin
        shifted = work;
        for (int m = 0; m < ROWS; m++) begin
            if (m == 0)
                shifted[0 +: COLS] = '0;
            else if (m <= int'(r))
                shifted[m*COLS +: COLS] = work[(m-1)*COLS +: COLS];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            work           <= '0;
            r              <= '0;
            cnt            <= '0;
            board_out_q    <= '0;
            rows_cleared_q <= '0;
            score_add_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work  <= {1'b0, bus.board_in[BW-2:0]};
                        r     <= 4'(ROWS-1);
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        cnt   <= cnt + 4'd1;
                        state <= SHIFT;
                    end else if (r != 4'd0) begin
                        r <= r - 4'd1;
                    end else begin
                        // Results are loaded on entry so they are valid alongside done.
                        board_out_q    <= work;
                        rows_cleared_q <= cnt;
                        score_add_q    <= 10'(cnt) * 10'(POINTS_PER_ROW);
                        state          <= DONE;
                    end
                end
                SHIFT: begin
                    work  <= shifted;
                    state <= SCAN;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.board_out    = board_out_q;
    assign bus.rows_cleared = rows_cleared_q;
    assign bus.score_add    = score_add_q;
endmodule
